// File: rtl/dma_pkg.sv
// Shared definitions for the DMA priority arbiter: channel count default,
// channel index type and arbiter state encoding.
package dma_pkg;

    localparam int NUM_CH_DEFAULT = 4;
    localparam int CH_W_DEFAULT   = $clog2(NUM_CH_DEFAULT);

    typedef logic [CH_W_DEFAULT-1:0] ch_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_GRANT,
        ST_RELEASE
    } arb_state_t;

endpackage

// File: rtl/dma_priority_encoder.sv
// Combinational channel arbitration: fixed (ch0 highest) or rotating priority
// where the channel after last_served is highest.
module dma_priority_encoder
    import dma_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEFAULT,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic              rotate,
    input  logic [CH_W-1:0]   last_served,
    output logic [CH_W-1:0]   winner,
    output logic              valid
);

    int base;
    int idx;

    // NOTE: every variable written here gets a default first, so no path
    // through the block can leave a value held over and infer a latch.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        base   = rotate ? (int'(last_served) + 1) : 0;
        if (base >= NUM_CH) begin
            base = 0;
        end
        // Walk from lowest priority to highest so the highest-priority hit is the last write.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = base + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (req[CH_W'(idx)]) begin
                winner = CH_W'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter: raises HRQ on any effective request, grants one channel
// per HLDA tenure and releases on EOP or end of transfer.
module dma_priority_arbiter
    import dma_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEFAULT
) (
    input  logic                                   CLK,
    input  logic                                   RESET_N,
    input  logic [NUM_CH-1:0]                      DREQ,
    input  logic [NUM_CH-1:0]                      swReq,
    input  logic [NUM_CH-1:0]                      maskReg,
    input  logic [NUM_CH-1:0]                      singleMode,
    input  logic                                   cmdRotating,
    input  logic                                   cmdDisable,
    input  logic                                   HLDA,
    input  logic                                   EOP_N,
    input  logic                                   cycleDone,
    output logic                                   HRQ,
    output logic [NUM_CH-1:0]                      DACK,
    output logic                                   grantValid,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] grantChannel
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [CH_W-1:0]   ch_q;
    logic [CH_W-1:0]   last_q;
    logic [NUM_CH-1:0] raw_req;
    logic [NUM_CH-1:0] eff_req;
    logic [CH_W-1:0]   win_ch;
    logic              win_valid;
    logic              release_go;

    always_comb begin
        raw_req = DREQ | swReq;
        eff_req = cmdDisable ? '0 : (raw_req & ~maskReg);
    end

    dma_priority_encoder #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_encoder (
        .req         (eff_req),
        .rotate      (cmdRotating),
        .last_served (last_q),
        .winner      (win_ch),
        .valid       (win_valid)
    );

    always_comb begin
        state_nxt  = state;
        release_go = 1'b0;
        case (state)
            ST_IDLE: begin
                if (win_valid) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (!win_valid) state_nxt = ST_IDLE;
                else if (HLDA)  state_nxt = ST_GRANT;
            end
            ST_GRANT: begin
                // Losing HLDA is an abort, not a completed service.
                if (!HLDA) begin
                    state_nxt = ST_IDLE;
                end else if (!EOP_N ||
                             (cycleDone && (singleMode[ch_q] || !raw_req[ch_q]))) begin
                    state_nxt  = ST_RELEASE;
                    release_go = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!HLDA) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= ST_IDLE;
            ch_q   <= '0;
            last_q <= CH_W'(NUM_CH - 1);
        end else begin
            state <= state_nxt;
            if (state == ST_REQ && HLDA && win_valid) begin
                ch_q <= win_ch;
            end
            if (release_go) begin
                last_q <= ch_q;
            end
        end
    end

    always_comb begin
        HRQ          = (state == ST_REQ) || (state == ST_GRANT);
        grantValid   = (state == ST_GRANT);
        grantChannel = ch_q;
        DACK         = '0;
        if (state == ST_GRANT) begin
            DACK[ch_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter: stimulus pushes expected grants,
// a monitor pops and compares on each new grant.
module tb_dma_priority_arbiter;
    import dma_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [3:0] DREQ, swReq, maskReg, singleMode;
    logic       cmdRotating, cmdDisable, HLDA, EOP_N, cycleDone;
    logic       HRQ;
    logic [3:0] DACK;
    logic       grantValid;
    logic [1:0] grantChannel;

    int pass_cnt  = 0;
    int total_cnt = 0;
    ch_idx_t sb[$];

    dma_priority_arbiter #(.NUM_CH(4)) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .DREQ         (DREQ),
        .swReq        (swReq),
        .maskReg      (maskReg),
        .singleMode   (singleMode),
        .cmdRotating  (cmdRotating),
        .cmdDisable   (cmdDisable),
        .HLDA         (HLDA),
        .EOP_N        (EOP_N),
        .cycleDone    (cycleDone),
        .HRQ          (HRQ),
        .DACK         (DACK),
        .grantValid   (grantValid),
        .grantChannel (grantChannel)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_sig(input bit sel_gv, input logic level, input string name);
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if ((sel_gv ? grantValid : HRQ) === level) return;
        end
        total_cnt++;
        $display("FAIL %s: timeout waiting for level %0b", name, level);
    endtask

    task automatic pulse_done();
        cycleDone = 1'b1;
        @(negedge CLK);
        cycleDone = 1'b0;
    endtask

    // Request, grant after HLDA, then one cycleDone (caller sets singleMode).
    task automatic serve(input logic [3:0] dreq_v, input ch_idx_t exp_ch, input string name);
        DREQ = dreq_v;
        sb.push_back(exp_ch);
        wait_sig(1'b0, 1'b1, {name, "_hrq"});
        tick(2);
        HLDA = 1'b1;
        wait_sig(1'b1, 1'b1, {name, "_grant"});
        pulse_done();
        wait_sig(1'b1, 1'b0, {name, "_release"});
        check({name, "_hrq_low_in_release"}, int'(HRQ), 0);
        HLDA = 1'b0;
        tick(1);
    endtask

    // Monitor: compare every new grant against the scoreboard head.
    initial begin
        logic    prev_gv;
        ch_idx_t exp;
        prev_gv = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (grantValid && !prev_gv) begin
                if (sb.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_grant: got ch %0d with no expected grant", grantChannel);
                end else begin
                    exp = sb.pop_front();
                    check("grant_channel", int'(grantChannel), int'(exp));
                    check("dack_onehot", int'(DACK), int'(4'b0001 << exp));
                end
            end
            prev_gv = grantValid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RESET_N = 1'b0; DREQ = '0; swReq = '0; maskReg = '0; singleMode = 4'b1111;
        cmdRotating = 1'b0; cmdDisable = 1'b0; HLDA = 1'b0; EOP_N = 1'b1; cycleDone = 1'b0;
        #12;
        check("reset_hrq", int'(HRQ), 0);
        check("reset_dack", int'(DACK), 0);
        check("reset_gv", int'(grantValid), 0);
        check("reset_gch", int'(grantChannel), 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        tick(1);

        // Fixed priority: 1010 -> ch1
        serve(4'b1010, 1, "fixed");

        // Rotating after ch1: 2, 3, 0
        cmdRotating = 1'b1;
        serve(4'b1111, 2, "rot2");
        serve(4'b1111, 3, "rot3");
        serve(4'b1111, 0, "rot0");

        // HLDA abort on ch1 must not advance lastServed
        sb.push_back(1);
        wait_sig(1'b0, 1'b1, "abort_hrq");
        tick(2);
        HLDA = 1'b1;
        wait_sig(1'b1, 1'b1, "abort_grant");
        HLDA = 1'b0;
        @(negedge CLK);
        check("abort_gv", int'(grantValid), 0);
        check("abort_hrq", int'(HRQ), 0);
        serve(4'b1111, 1, "after_abort");
        DREQ = '0;
        cmdRotating = 1'b0;
        tick(3);

        // Demand mode: three pulses with DREQ held, release on the fourth
        singleMode = 4'b0000;
        DREQ = 4'b0001;
        sb.push_back(0);
        wait_sig(1'b0, 1'b1, "demand_hrq");
        tick(2);
        HLDA = 1'b1;
        wait_sig(1'b1, 1'b1, "demand_grant");
        for (int p = 0; p < 3; p++) begin
            pulse_done();
            check("demand_hold", int'(grantValid), 1);
            tick(1);
        end
        DREQ = '0;
        tick(1);
        pulse_done();
        check("demand_release", int'(grantValid), 0);
        HLDA = 1'b0;
        tick(2);

        // Single mode: release after the first pulse, no HRQ while HLDA stays
        singleMode = 4'b0001;
        DREQ = 4'b0001;
        sb.push_back(0);
        wait_sig(1'b0, 1'b1, "single_hrq");
        tick(2);
        HLDA = 1'b1;
        wait_sig(1'b1, 1'b1, "single_grant");
        pulse_done();
        check("single_release", int'(grantValid), 0);
        tick(2);
        check("single_no_rereq", int'(HRQ), 0);
        HLDA = 1'b0;
        DREQ = '0;
        tick(2);

        // EOP with coincident cycleDone, DREQ still high
        singleMode = 4'b0000;
        DREQ = 4'b0001;
        sb.push_back(0);
        wait_sig(1'b0, 1'b1, "eop_hrq");
        tick(2);
        HLDA = 1'b1;
        wait_sig(1'b1, 1'b1, "eop_grant");
        EOP_N = 1'b0;
        cycleDone = 1'b1;
        @(negedge CLK);
        EOP_N = 1'b1;
        cycleDone = 1'b0;
        check("eop_dack", int'(DACK), 0);
        check("eop_hrq", int'(HRQ), 0);
        tick(3);
        check("eop_no_rereq", int'(HRQ), 0);
        HLDA = 1'b0;
        wait_sig(1'b0, 1'b1, "eop_rereq");
        DREQ = '0;
        tick(2);
        check("req_withdraw_hrq", int'(HRQ), 0);

        // Disable and mask block requests; swReq still arbitrates
        cmdDisable = 1'b1;
        DREQ = 4'b0001;
        tick(4);
        check("disable_hrq", int'(HRQ), 0);
        cmdDisable = 1'b0;
        maskReg = 4'b0001;
        tick(4);
        check("mask_hrq", int'(HRQ), 0);
        singleMode = 4'b1111;
        swReq = 4'b0100;
        serve(4'b0001, 2, "swreq");
        swReq = '0;
        maskReg = '0;
        DREQ = '0;
        tick(3);

        // Grant ch3, try to preempt, then reset mid-grant
        DREQ = 4'b1000;
        sb.push_back(3);
        wait_sig(1'b0, 1'b1, "rst_hrq");
        tick(2);
        HLDA = 1'b1;
        wait_sig(1'b1, 1'b1, "rst_grant");
        DREQ = 4'b1001;
        maskReg = 4'b1000;
        cmdDisable = 1'b1;
        tick(3);
        check("no_preempt_gv", int'(grantValid), 1);
        check("no_preempt_ch", int'(grantChannel), 3);
        maskReg = '0;
        cmdDisable = 1'b0;
        @(posedge CLK);
        #3;
        RESET_N = 1'b0;
        #1;
        check("async_rst_hrq", int'(HRQ), 0);
        check("async_rst_dack", int'(DACK), 0);
        check("async_rst_gv", int'(grantValid), 0);
        check("async_rst_gch", int'(grantChannel), 0);
        @(negedge CLK);
        HLDA = 1'b0;
        RESET_N = 1'b1;
        cmdRotating = 1'b1;
        serve(4'b1111, 0, "post_reset");
        DREQ = '0;
        tick(4);

        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
